data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
//  Responder end of the MEM-stage data-memory request interface: the pipeline issues LDUR/STUR
//  doubleword requests (address = ALU result, write data = read_data2), and this block serves them.
//  Fixed multi-cycle latency with a valid/ready handshake; drives a stall the hazard logic freezes
//  EX/MEM on. Replaces the single-cycle combinational data_memory once MEM/WB is in place.
// PARAMETERS
//  ADDR_WIDTH  10  byte-address bits decoded; memory holds 2**ADDR_WIDTH bytes (ADDR_WIDTH >= 3)
//  LATENCY     2   cycles from request acceptance to response (1..15)
// PORTS
//  clock           in   1   rising-edge clock
//  reset           in   1   synchronous, active-high reset
//  req_valid       in   1   MEM stage presents a request (MemRead | MemWrite)
//  req_ready       out  1   responder can accept a request this cycle
//  req_write       in   1   1 = store doubleword (STUR), 0 = load doubleword (LDUR)
//  req_address     in   64  byte address from ALU
//  req_write_data  in   64  store data
//  resp_valid      out  1   one-cycle pulse: response for the accepted request
//  resp_read_data  out  64  load data; 0 for stores and errors
//  resp_error      out  1   valid with resp_valid: request was misaligned, no access done
//  stall           out  1   1 while a request is accepted but not yet answered
// BEHAVIOUR
//  - Reset (sync, active-high): state IDLE, counter 0, req_ready=0 during reset cycle then 1,
//    resp_valid=0, resp_read_data=0, resp_error=0, stall=0. Memory contents are NOT cleared.
//  - FSM: IDLE -> BUSY -> RESP -> IDLE.
//    IDLE: req_ready=1, stall=0. Accept on rising edge where req_valid & req_ready; latch
//      req_write, req_address, req_write_data; load counter with LATENCY-1; go BUSY.
//    BUSY: req_ready=0, stall=1; req_* inputs ignored. Counter decrements each edge; at the edge
//      where counter==0: perform access, register results, go RESP.
//    RESP: resp_valid=1 for exactly this cycle, stall=0, req_ready=0; next edge -> IDLE.
//  - Timing: request accepted at edge k => access at edge k+LATENCY => resp_valid high in the
//    cycle following edge k+LATENCY. Back-to-back throughput: one request per LATENCY+2 cycles.
//  - Access: little-endian, byte-addressed. index = latched_address[ADDR_WIDTH-1:3]; bits above
//    ADDR_WIDTH-1 ignored (address wraps modulo 2**ADDR_WIDTH).
//    Store: writes all 8 bytes at the access edge; resp_read_data=0.
//    Load: resp_read_data = doubleword at index as of the access edge (read-before-write n/a).
//  - Misaligned (latched_address[2:0] != 0): no memory write, resp_read_data=0, resp_error=1.
//  - resp_read_data/resp_error hold their value after RESP until the next response; only
//    resp_valid qualifies them.
//  - Reset mid-operation (BUSY or RESP): request dropped, no response issued; a store whose
//    access edge coincides with reset is NOT committed.
//  - req_valid deasserting while BUSY has no effect; the latched request completes.
// TESTING
//  1. Reset 2 cycles -> all outputs 0; first cycle after reset req_ready=1, stall=0.
//  2. LATENCY=2: STUR addr 0x10 data 0x0123456789ABCDEF, accept at edge k -> stall=1 for 2 cycles,
//     resp_valid pulse after edge k+2, resp_error=0, resp_read_data=0.
//  3. LDUR addr 0x10 next -> resp_read_data=0x0123456789ABCDEF; byte at addr 0x10 = 0xEF (little-endian).
//  4. Wrap: STUR addr (0x10 + 2**ADDR_WIDTH) data 0xAA -> LDUR addr 0x10 returns 0xAA.
//  5. LDUR/STUR addr 0x13 -> resp_error=1, resp_read_data=0, memory at 0x10 unchanged.
//  6. Reset asserted at store's access edge -> no resp_valid; later LDUR shows old contents.

Source files
------------

// File: rtl/data_memory_responder.sv
// Data-memory responder for the MEM stage: serves LDUR/STUR doubleword requests with a fixed
// latency over a valid/ready handshake and raises stall while a request is in flight.
module data_memory_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_address,
  input  logic [63:0] req_write_data,
  output logic        resp_valid,
  output logic [63:0] resp_read_data,
  output logic        resp_error,
  output logic        stall
);

  localparam int unsigned Words = 2 ** (ADDR_WIDTH - 3);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                  state_q;
  logic [3:0]              count_q;
  logic                    write_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [63:0]             wdata_q;
  logic [63:0]             mem [Words];

  logic [ADDR_WIDTH-4:0]   index;
  logic                    aligned;
  logic                    access;

  // Address bits above the decoded range wrap and are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^req_address[63:ADDR_WIDTH];

  assign index   = addr_q[ADDR_WIDTH-1:3];
  assign aligned = (addr_q[2:0] == 3'b000);
  assign access  = (state_q == StBusy) && (count_q == 4'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      count_q        <= 4'd0;
      req_ready      <= 1'b0;
      resp_valid     <= 1'b0;
      resp_read_data <= '0;
      resp_error     <= 1'b0;
      stall          <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            write_q   <= req_write;
            addr_q    <= req_address[ADDR_WIDTH-1:0];
            wdata_q   <= req_write_data;
            count_q   <= 4'(LATENCY - 1);
            state_q   <= StBusy;
            req_ready <= 1'b0;
            stall     <= 1'b1;
          end
        end
        StBusy: begin
          if (count_q == 4'd0) begin
            state_q        <= StResp;
            stall          <= 1'b0;
            resp_valid     <= 1'b1;
            resp_error     <= !aligned;
            resp_read_data <= (aligned && !write_q) ? mem[index] : '0;
          end else begin
            count_q <= count_q - 4'd1;
          end
        end
        StResp: begin
          state_q    <= StIdle;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Kept out of the reset branch so contents survive reset; a store coinciding with reset is lost.
  always_ff @(posedge clock) begin
    if (!reset && access && write_q && aligned) begin
      mem[index] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: byte-array reference model with per-cycle
// output comparison, directed scenarios with literal expectations, and randomized traffic.
module tb_data_memory_responder;

  localparam int unsigned AW  = 10;
  localparam int unsigned LAT = 2;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_address;
  logic [63:0] req_write_data;
  logic        resp_valid;
  logic [63:0] resp_read_data;
  logic        resp_error;
  logic        stall;

  int checks = 0;
  int errors = 0;

  data_memory_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_address    (req_address),
    .req_write_data (req_write_data),
    .resp_valid     (resp_valid),
    .resp_read_data (resp_read_data),
    .resp_error     (resp_error),
    .stall          (stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory plus cycle-count timing.
  logic [7:0]  mdl [2**AW];
  bit          model_on = 0;
  bit          pending  = 0;
  int          cyc      = 0;
  int          acc_cyc  = 0;
  bit          m_ready, m_valid, m_stall, m_err;
  logic [63:0] m_rd;
  logic        m_w;
  logic [63:0] m_a, m_d;

  task automatic model_access();
    int base;
    base = int'(m_a[AW-1:0]);
    if (m_a[2:0] != 3'b000) begin
      m_rd = 64'd0;
      m_err = 1'b1;
    end else if (m_w) begin
      for (int b = 0; b < 8; b++) mdl[base + b] = m_d[8*b +: 8];
      m_rd = 64'd0;
      m_err = 1'b0;
    end else begin
      for (int b = 0; b < 8; b++) m_rd[8*b +: 8] = mdl[base + b];
      m_err = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      if (reset) begin
        model_on = 1;
        pending  = 0;
        m_ready  = 0;
        m_valid  = 0;
        m_stall  = 0;
        m_rd     = 64'd0;
        m_err    = 0;
      end else if (model_on) begin
        if (pending) begin
          if (cyc == acc_cyc + int'(LAT)) begin
            pending = 0;
            m_stall = 0;
            m_valid = 1;
            model_access();
          end else begin
            m_stall = 1;
          end
        end else if (m_valid) begin
          m_valid = 0;
          m_ready = 1;
        end else if (m_ready && req_valid) begin
          pending = 1;
          acc_cyc = cyc;
          m_w     = req_write;
          m_a     = req_address;
          m_d     = req_write_data;
          m_stall = 1;
          m_ready = 0;
        end else begin
          m_ready = 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (model_on) begin
        check("req_ready", {63'd0, req_ready}, {63'd0, m_ready});
        check("stall", {63'd0, stall}, {63'd0, m_stall});
        check("resp_valid", {63'd0, resp_valid}, {63'd0, m_valid});
        check("resp_error", {63'd0, resp_error}, {63'd0, m_err});
        check("resp_read_data", resp_read_data, m_rd);
      end
    end
  end

  // Called at a negedge; returns at the negedge where resp_valid is seen.
  task automatic do_req(input logic w, input logic [63:0] a, input logic [63:0] d,
                        output logic [63:0] rd, output logic er, output int stalls);
    int n;
    req_valid      = 1'b1;
    req_write      = w;
    req_address    = a;
    req_write_data = d;
    n = 0;
    while (stall !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=%0d expected<20", n);
    end
    // Inputs are ignored while busy, so scramble them.
    req_valid      = 1'($urandom_range(0, 1));
    req_write      = 1'($urandom_range(0, 1));
    req_address    = {$urandom, $urandom};
    req_write_data = {$urandom, $urandom};
    stalls = 0;
    n = 0;
    while (resp_valid !== 1'b1 && n < 40) begin
      if (stall === 1'b1) stalls++;
      @(negedge clock);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout actual=%0d expected<40", n);
    end
    req_valid = 1'b0;
    rd = resp_read_data;
    er = resp_error;
  endtask

  initial begin
    logic [63:0] rd;
    logic        er;
    int          st;
    int          n;
    reset          = 1'b1;
    req_valid      = 1'b0;
    req_write      = 1'b0;
    req_address    = 64'd0;
    req_write_data = 64'd0;

    repeat (2) @(negedge clock);
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_read_data", resp_read_data, 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("post_rst_stall", {63'd0, stall}, 64'd0);

    // Fill every doubleword with random data so later loads are defined.
    for (int i = 0; i < 2**(AW-3); i++) begin
      do_req(1'b1, 64'(i * 8), {$urandom, $urandom}, rd, er, st);
    end

    do_req(1'b1, 64'h10, 64'h0123456789ABCDEF, rd, er, st);
    check("stur_err", {63'd0, er}, 64'd0);
    check("stur_rdata", rd, 64'd0);
    check("stur_stall_cycles", 64'(st), 64'(LAT));

    do_req(1'b0, 64'h10, 64'd0, rd, er, st);
    check("ldur_rdata", rd, 64'h0123456789ABCDEF);
    check("ldur_byte0", {56'd0, rd[7:0]}, 64'hEF);
    check("model_byte_0x10", {56'd0, mdl[16]}, 64'hEF);

    do_req(1'b1, 64'h10 + 64'(2**AW), 64'hAA, rd, er, st);
    do_req(1'b0, 64'h10, 64'd0, rd, er, st);
    check("wrap_rdata", rd, 64'hAA);

    do_req(1'b0, 64'h13, 64'd0, rd, er, st);
    check("mis_ld_err", {63'd0, er}, 64'd1);
    check("mis_ld_rdata", rd, 64'd0);
    do_req(1'b1, 64'h13, 64'hFFFF_FFFF_FFFF_FFFF, rd, er, st);
    check("mis_st_err", {63'd0, er}, 64'd1);
    check("mis_st_rdata", rd, 64'd0);
    do_req(1'b0, 64'h10, 64'd0, rd, er, st);
    check("mis_unchanged", rd, 64'hAA);

    // Reset lands on the store's access edge: no response, no commit.
    req_valid      = 1'b1;
    req_write      = 1'b1;
    req_address    = 64'h10;
    req_write_data = 64'h5555;
    n = 0;
    while (stall !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("rst_store_accepted", {63'd0, stall}, 64'd1);
    req_valid = 1'b0;
    repeat (LAT - 1) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rst_store_no_resp", {63'd0, resp_valid}, 64'd0);
    reset = 1'b0;
    @(negedge clock);
    do_req(1'b0, 64'h10, 64'd0, rd, er, st);
    check("rst_store_old_data", rd, 64'hAA);

    for (int i = 0; i < 150; i++) begin
      logic [63:0] a;
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a[2:0] = 3'b000;
      do_req(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, rd, er, st);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
